// File: rtl/kj_stream_buffer_pkg.sv
// Shared widths and lane addressing for the K-in / J-out stream buffer.
package kj_stream_buffer_pkg;

  localparam int DEF_SIZE  = 16;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_K     = 4;
  localparam int DEF_J     = 4;

  localparam int DEF_BIT   = $clog2(DEF_SIZE);
  localparam int DEF_CNT_W = $clog2(DEF_SIZE + 1);
  localparam int DEF_KC_W  = $clog2(DEF_K + 1);
  localparam int DEF_JC_W  = $clog2(DEF_J + 1);

  // Word address of a lane relative to a base pointer, wrapped into the buffer.
  function automatic int unsigned lane_addr(input int unsigned base,
                                            input int unsigned lane,
                                            input int unsigned size);
    return (base + lane) % size;
  endfunction

endpackage

// File: rtl/kj_stream_buffer_if.sv
// Producer/consumer handshake bundle for the stream buffer.
interface kj_stream_buffer_if
  import kj_stream_buffer_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int WIDTH = DEF_WIDTH,
  parameter int K     = DEF_K,
  parameter int J     = DEF_J
);
  localparam int CNT_W = $clog2(SIZE + 1);
  localparam int KC_W  = $clog2(K + 1);
  localparam int JC_W  = $clog2(J + 1);

  logic                 flush;
  logic                 drain;
  logic                 wr_valid;
  logic [KC_W-1:0]      wr_count;
  logic [WIDTH*K-1:0]   par_in;
  logic                 wr_ready;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [JC_W-1:0]      rd_count;
  logic [WIDTH*J-1:0]   par_out;
  logic [CNT_W-1:0]     occupancy;
  logic [CNT_W-1:0]     free;
  logic                 full;
  logic                 empty;

  modport master (
    output flush, drain, wr_valid, wr_count, par_in, rd_ready,
    input  wr_ready, rd_valid, rd_count, par_out, occupancy, free, full, empty
  );

  modport slave (
    input  flush, drain, wr_valid, wr_count, par_in, rd_ready,
    output wr_ready, rd_valid, rd_count, par_out, occupancy, free, full, empty
  );

endinterface

// File: rtl/kj_stream_buffer_rotator.sv
// Expands a base pointer and lane count into per-lane word addresses and enables.
module kj_lane_rotator
  import kj_stream_buffer_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int N    = DEF_K,
  parameter int BIT  = $clog2(SIZE),
  parameter int CW   = $clog2(N + 1)
) (
  input  logic [BIT-1:0] base,
  input  logic [CW-1:0]  count,
  output logic [BIT-1:0] addr [N],
  output logic [N-1:0]   en
);

  // Lane i is live when it falls below the count; counts above N enable all lanes.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign addr[i] = BIT'(lane_addr(32'(base), i, SIZE));
    assign en[i]   = (count > CW'(i));
  end

endmodule

// File: rtl/kj_stream_buffer.sv
// Circular word buffer: up to K words in per beat, J words (or a drained tail) out per beat.
module kj_stream_buffer
  import kj_stream_buffer_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int WIDTH = DEF_WIDTH,
  parameter int K     = DEF_K,
  parameter int J     = DEF_J,
  parameter int BIT   = $clog2(SIZE),
  parameter int CNT_W = $clog2(SIZE + 1),
  parameter int KC_W  = $clog2(K + 1),
  parameter int JC_W  = $clog2(J + 1)
) (
  input  logic                clk,
  input  logic                rst,
  kj_stream_buffer_if.slave   bus
);

  logic [WIDTH-1:0] mem [SIZE];
  logic [BIT-1:0]   wr_ptr;
  logic [BIT-1:0]   rd_ptr;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] free_w;
  logic [KC_W-1:0]  wr_cnt_eff;
  logic [JC_W-1:0]  rd_cnt;
  logic             wr_ready_w;
  logic             wr_fire;
  logic             rd_fire;
  logic [BIT-1:0]   waddr [K];
  logic [K-1:0]     wen;
  logic [BIT-1:0]   raddr [J];
  logic [J-1:0]     ren;

  assign free_w     = CNT_W'(SIZE) - occ;
  // Ready only when a full K-word beat fits, regardless of the offered count.
  assign wr_ready_w = (free_w >= CNT_W'(K));
  // Oversized counts are clamped to K so pointers and occupancy stay consistent.
  assign wr_cnt_eff = (bus.wr_count > KC_W'(K)) ? KC_W'(K) : bus.wr_count;
  assign wr_fire    = bus.wr_valid & wr_ready_w & (wr_cnt_eff != '0);
  assign rd_fire    = (rd_cnt != '0) & bus.rd_ready;

  // Read beat size: a full J beat, or the whole tail when draining.
  always_comb begin
    rd_cnt = '0;
    if (occ >= CNT_W'(J))
      rd_cnt = JC_W'(J);
    else if (bus.drain && (occ != '0))
      rd_cnt = JC_W'(occ);
  end

  kj_lane_rotator #(.SIZE(SIZE), .N(K), .BIT(BIT), .CW(KC_W)) u_wr_rot (
    .base  (wr_ptr),
    .count (wr_cnt_eff),
    .addr  (waddr),
    .en    (wen)
  );

  kj_lane_rotator #(.SIZE(SIZE), .N(J), .BIT(BIT), .CW(JC_W)) u_rd_rot (
    .base  (rd_ptr),
    .count (rd_cnt),
    .addr  (raddr),
    .en    (ren)
  );

  // Storage: cleared on reset, kept across flush and reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < SIZE; w++) mem[w] <= '0;
    end else if (wr_fire && !bus.flush) begin
      for (int i = 0; i < K; i++)
        if (wen[i]) mem[waddr[i]] <= bus.par_in[WIDTH*i +: WIDTH];
    end
  end

  // Pointers and occupancy; flush drops the same-cycle write and read.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + BIT'(wr_cnt_eff);
      if (rd_fire) rd_ptr <= rd_ptr + BIT'(rd_cnt);
      occ <= occ + (wr_fire ? CNT_W'(wr_cnt_eff) : '0)
                 - (rd_fire ? CNT_W'(rd_cnt) : '0);
    end
  end

  // Read lanes past the beat size are forced to zero.
  for (genvar i = 0; i < J; i++) begin : g_out
    assign bus.par_out[WIDTH*i +: WIDTH] = ren[i] ? mem[raddr[i]] : '0;
  end

  assign bus.wr_ready  = wr_ready_w;
  assign bus.rd_valid  = (rd_cnt != '0);
  assign bus.rd_count  = rd_cnt;
  assign bus.occupancy = occ;
  assign bus.free      = free_w;
  assign bus.full      = (occ == CNT_W'(SIZE));
  assign bus.empty     = (occ == '0);

endmodule

// File: tb/tb_kj_stream_buffer.sv
// Scoreboard bench for kj_stream_buffer at default parameters (SIZE=16, K=4, J=4, WIDTH=8).
module tb_kj_stream_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kj_stream_buffer_if bus ();
  kj_stream_buffer dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [7:0]  sb [$];     // expected buffer contents, oldest first
  logic [63:0] exp_q [$];  // expected read beats {rd_count, par_out}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT read handshake is matched against the next expected beat.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid && bus.rd_ready && !bus.flush) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got %0h expected no beat at %0t",
                 {bus.rd_count, bus.par_out}, $time);
      end else begin
        check("rd_beat", 64'({bus.rd_count, bus.par_out}), exp_q.pop_front());
      end
    end
  end

  // One cycle: drive inputs, check status against the model, push expected beat, advance model.
  task automatic step(input bit wv, input int wc, input logic [31:0] data,
                      input bit rr, input bit dr, input bit fl, input bit r);
    int sz, rc, fr;
    bit exp_wrdy, wfire, rfire;
    logic [31:0] beat;
    rst          = r;
    bus.wr_valid = wv;
    bus.wr_count = 3'(wc);
    bus.par_in   = data;
    bus.rd_ready = rr;
    bus.drain    = dr;
    bus.flush    = fl;
    if (wc > 4) begin
      bad++;
      $display("FAIL stim_wr_count: got %0d expected <= 4", wc);
    end
    #1;
    sz       = sb.size();
    fr       = 16 - sz;
    exp_wrdy = (fr >= 4);
    rc       = (sz >= 4) ? 4 : ((dr && sz > 0) ? sz : 0);
    beat     = '0;
    for (int i = 0; i < rc; i++) beat[8*i +: 8] = sb[i];
    if (!r) begin
      check("occupancy", 64'(bus.occupancy), 64'(sz));
      check("free",      64'(bus.free), 64'(fr));
      check("occ_plus_free", 64'(bus.occupancy) + 64'(bus.free), 64'd16);
      check("full",      64'(bus.full), 64'(sz == 16));
      check("empty",     64'(bus.empty), 64'(sz == 0));
      check("wr_ready",  64'(bus.wr_ready), 64'(exp_wrdy));
      check("rd_count",  64'(bus.rd_count), 64'(rc));
      check("rd_valid",  64'(bus.rd_valid), 64'(rc != 0));
      if (rc == 0) check("par_out_idle", 64'(bus.par_out), 64'd0);
    end
    if (r || fl) begin
      sb.delete();
    end else begin
      wfire = wv && exp_wrdy && (wc != 0);
      rfire = rr && (rc != 0);
      if (rfire) begin
        exp_q.push_back({29'd0, 3'(rc), beat});
        for (int i = 0; i < rc; i++) void'(sb.pop_front());
      end
      if (wfire)
        for (int i = 0; i < wc; i++) sb.push_back(data[8*i +: 8]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit dr);
    step(0, 0, 32'd0, 0, dr, 0, 0);
  endtask

  function automatic logic [31:0] seq4(input int b);
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  initial begin
    bus.flush = 0; bus.drain = 0; bus.wr_valid = 0; bus.wr_count = '0;
    bus.par_in = '0; bus.rd_ready = 0;
    @(posedge clk); #1;
    step(0, 0, 32'd0, 0, 0, 0, 1);
    step(0, 0, 32'd0, 0, 0, 0, 1);
    idle(1);

    // Fill with 0x00..0x0F, then read back four full beats.
    for (int b = 0; b < 4; b++) step(1, 4, seq4(4 * b), 0, 0, 0, 0);
    step(1, 4, 32'hDEADBEEF, 0, 0, 0, 0);  // refused: buffer full
    for (int b = 0; b < 4; b++) step(0, 0, 32'd0, 1, 0, 0, 0);
    idle(0);

    // Partial tail held back until drain is raised.
    step(1, 3, 32'h00A2A1A0, 0, 0, 0, 0);
    step(0, 0, 32'd0, 1, 0, 0, 0);
    step(0, 0, 32'd0, 1, 1, 0, 0);
    idle(1);

    // Move both pointers to 14, then write a beat that straddles the wrap.
    step(1, 4, seq4(8'h10), 0, 0, 0, 0);
    step(1, 4, seq4(8'h14), 0, 0, 0, 0);
    step(1, 3, seq4(8'h18), 0, 0, 0, 0);
    step(0, 0, 32'd0, 1, 0, 0, 0);
    step(0, 0, 32'd0, 1, 0, 0, 0);
    step(0, 0, 32'd0, 1, 1, 0, 0);
    step(1, 4, seq4(8'h50), 0, 0, 0, 0);
    step(0, 0, 32'd0, 1, 0, 0, 0);
    idle(0);

    // Simultaneous write of 2 and read of 4 from occupancy 8.
    step(1, 4, seq4(8'h60), 0, 0, 0, 0);
    step(1, 4, seq4(8'h64), 0, 0, 0, 0);
    step(1, 2, 32'h0000_7170, 1, 0, 0, 0);
    idle(0);
    step(0, 0, 32'd0, 1, 1, 0, 0);
    step(0, 0, 32'd0, 1, 1, 0, 0);
    idle(1);

    // Flush beats a same-cycle write and read.
    for (int b = 0; b < 3; b++) step(1, 4, seq4(8'h80 + 4 * b), 0, 0, 0, 0);
    step(1, 4, seq4(8'hC0), 1, 1, 1, 0);
    idle(1);

    // Reset together with flush restores reset values.
    step(1, 4, seq4(8'h90), 0, 0, 0, 0);
    step(1, 4, seq4(8'h94), 0, 0, 0, 0);
    step(1, 4, seq4(8'hE0), 1, 1, 1, 1);
    idle(1);
    idle(0);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4)), $urandom(),
           $urandom_range(0, 4) < 3, $urandom_range(0, 9) < 3,
           $urandom_range(0, 63) == 0, 0);
    end

    // Drain everything left and confirm every expected beat was seen.
    for (int n = 0; n < 6; n++) step(0, 0, 32'd0, 1, 1, 0, 0);
    idle(0);
    check("beats_outstanding", 64'(exp_q.size()), 64'd0);
    check("final_empty", 64'(bus.empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kj_stream_buffer.md
Name: kj_stream_buffer

Overview:
- Parametrised K-in / J-out circular word buffer with internally managed read/write pointers and valid/ready handshakes on both sides.
- Accepts 1..K words per write beat and delivers J words per read beat, with an optional drain mode for partial final reads.
- Replaces externally supplied write/read addresses in the datapath between the K-wide producer and the J-wide consumer stages.

Parameters:
- SIZE, 16: buffer depth in words; must be a power of 2, SIZE >= K and SIZE >= J.
- WIDTH, 8: bits per word.
- K, 4: maximum words per write beat.
- J, 4: words per read beat.
- BIT, $clog2(SIZE): pointer width.
- CNT_W, $clog2(SIZE+1): occupancy/free counter width.
- KC_W, $clog2(K+1): write-count width.
- JC_W, $clog2(J+1): read-count width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous empty request.
- drain  in  1  permits partial reads when 0 < occupancy < J.
- wr_valid  in  1  write beat offered.
- wr_count  in  KC_W  number of valid words in par_in, taken from lane 0 upward.
- par_in  in  WIDTH*K  write lanes; lane i is bits [WIDTH*(i+1)-1 : WIDTH*i].
- wr_ready  out  1  buffer can accept a full K-word beat.
- rd_valid  out  1  read beat available.
- rd_ready  in  1  consumer takes the beat.
- rd_count  out  JC_W  number of valid words in par_out.
- par_out  out  WIDTH*J  read lanes, lane 0 oldest.
- occupancy  out  CNT_W  words stored.
- free  out  CNT_W  SIZE - occupancy.
- full  out  1  occupancy == SIZE.
- empty  out  1  occupancy == 0.

Behaviour:
- Reset: wr_ptr, rd_ptr and occupancy return to 0 and all storage words clear to 0.
  - After reset: wr_ready=1, rd_valid=0, rd_count=0, par_out=0, occupancy=0, free=SIZE, empty=1, full=0.
- wr_ready = (free >= K). It is registered-state derived and never depends on wr_valid or wr_count.
- Write fire = wr_valid & wr_ready & (wr_count != 0).
  - On fire: mem[(wr_ptr+i) mod SIZE] <= lane i for i < wr_count; wr_ptr advances by wr_count mod SIZE.
  - wr_count > K is illegal; the RTL treats it as K and the bench flags it.
- rd_count:
  - J when occupancy >= J.
  - occupancy when drain=1 and 0 < occupancy < J.
  - 0 otherwise.
- rd_valid = (rd_count != 0).
- par_out lane i = mem[(rd_ptr+i) mod SIZE] for i < rd_count; lanes i >= rd_count read 0. par_out is combinational from storage and pointers.
- Read fire = rd_valid & rd_ready. On fire, rd_ptr advances by rd_count mod SIZE. Storage is not cleared on read.
- Occupancy update each cycle: occupancy <= occupancy + (write fire ? wr_count : 0) - (read fire ? rd_count : 0).
  - Simultaneous write and read in one cycle is legal.
- Write-to-read latency is 1 cycle. There is no bypass: words written at edge n count toward rd_valid from cycle n+1.
- Wrap-around: all lane addressing is modulo SIZE. A beat straddling SIZE-1 to 0 splits cleanly.
- Full: wr_ready=0 whenever free < K, even if free >= wr_count. Reads still proceed.
- Empty: rd_valid=0 and par_out=0. drain has no effect.
- drain may toggle on any cycle. A partial read beat is atomic: the whole rd_count is consumed.
- Flush has priority over the same-cycle write and read; both are discarded.
  - Pointers and occupancy go to 0. Storage is kept.
  - Outputs are post-flush values from the next cycle.
- rst has priority over flush.
- Reset asserted mid-stream discards all contents regardless of in-flight handshakes.
- Invariant: occupancy + free == SIZE at all times. occupancy never exceeds SIZE or underflows.

Decomposition:
- Shared package holds:
  - clog2-derived width localparams (BIT, CNT_W, KC_W, JC_W);
  - a lane-address function: (base + lane) mod SIZE.
- Natural sub-module: kj_lane_rotator.
  - Inputs: base pointer and N-lane count.
  - Produces per-lane SIZE addresses and lane-enable masks.
  - Instantiated twice: write decode with N=K, read mux with N=J.
- Storage is a SIZE x WIDTH register array with per-word write enable, inside kj_stream_buffer.

Test Plan:
- Defaults (SIZE=16, K=4, J=4, WIDTH=8). Reset, then write 4 beats of wr_count=4, data 0x00..0x0F:
  - Expected: occupancy=16, full=1, wr_ready=0 after beat 3 fires.
  - Then 4 reads return lanes 0x00-0x03, 0x04-0x07, 0x08-0x0B, 0x0C-0x0F.
- Write wr_count=3 (0xA0-0xA2):
  - Expected: rd_valid=0 with drain=0.
  - Raise drain: rd_count=3, par_out={0,0xA2,0xA1,0xA0}. After read fire, empty=1.
- Wrap-around: advance pointers to 14, write 4 words 0x50-0x53:
  - Expected: stored at addresses 14, 15, 0, 1; read returns 0x50-0x53 in order.
- Simultaneous ops: occupancy=8, same-cycle write fire (count 2) and read fire (count 4):
  - Expected: occupancy=6 next cycle, free=10.
- Flush and reset priority:
  - occupancy=12, assert flush with wr_valid and rd_ready high: next cycle occupancy=0, empty=1, no data read.
  - Repeat with rst and flush both high: all outputs at reset values.
- Random stress: 2000 cycles of random valid/ready/wr_count/drain/flush against a scoreboard queue.
  - Expected: data order preserved, occupancy+free==16 every cycle, wr_count>K never issued.
